// File: rtl/sk_stream_out_pkg.sv
// Shared constants and section-tag enumeration for the secret-key word streamer.
// Optional feature macro used by sk_stream_out: SK_STREAM_ZEROIZE_EN.
package sk_stream_out_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned SK_BITS = 32256;
    localparam int unsigned N_WORDS = SK_BITS / WORD_W;
    localparam int unsigned IDX_W   = 10;

    // First word index of each section; IDX_END is one past the final word.
    localparam logic [IDX_W-1:0] IDX_KEY = 10'd8;
    localparam logic [IDX_W-1:0] IDX_TR  = 10'd16;
    localparam logic [IDX_W-1:0] IDX_S1  = 10'd32;
    localparam logic [IDX_W-1:0] IDX_S2  = 10'd192;
    localparam logic [IDX_W-1:0] IDX_T0  = 10'd384;
    localparam logic [IDX_W-1:0] IDX_END = 10'd1008;

    typedef enum logic [2:0] {
        SECT_RHO = 3'd0,
        SECT_KEY = 3'd1,
        SECT_TR  = 3'd2,
        SECT_S1  = 3'd3,
        SECT_S2  = 3'd4,
        SECT_T0  = 3'd5
    } sect_t;

endpackage

// File: rtl/sk_stream_out_sect_decode.sv
// Combinational map from stream word index to section tag and last-word flag.
module sk_sect_decode
    import sk_stream_out_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output sect_t            sect,
    output logic             last
);

    always_comb begin
        sect = SECT_T0;
        if (idx < IDX_KEY)
            sect = SECT_RHO;
        else if (idx < IDX_TR)
            sect = SECT_KEY;
        else if (idx < IDX_S1)
            sect = SECT_TR;
        else if (idx < IDX_S2)
            sect = SECT_S1;
        else if (idx < IDX_T0)
            sect = SECT_S2;
        last = (idx == (IDX_END - 10'd1));
    end

endmodule

// File: rtl/sk_stream_out.sv
// Streams a packed secret key out as little-endian 32-bit words with valid/ready.
// Define SK_STREAM_ZEROIZE_EN to clear the key register after completion or abort.
module sk_stream_out #(
    parameter int unsigned WORD_W  = sk_stream_out_pkg::WORD_W,
    parameter int unsigned SK_BITS = sk_stream_out_pkg::SK_BITS,
    parameter int unsigned N_WORDS = sk_stream_out_pkg::N_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [SK_BITS-1:0] sk_in,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [2:0]         out_sect,
    output logic               busy,
    output logic               done
);

    import sk_stream_out_pkg::*;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [SK_BITS-1:0] sr;
    sect_t              dec_sect;
    logic               dec_last;

    sk_sect_decode u_sect_decode (
        .idx  (idx),
        .sect (dec_sect),
        .last (dec_last)
    );

    // The register may hold residue while idle, so every data-path output is gated by busy.
    assign out_data = busy ? sr[WORD_W-1:0] : '0;
    assign out_sect = busy ? dec_sect : SECT_RHO;
    assign out_last = busy & dec_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            sr        <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        sr        <= sk_in;
                        idx       <= '0;
                        state     <= ST_STREAM;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
`ifdef SK_STREAM_ZEROIZE_EN
                        sr        <= '0;
`endif
                    end else if (out_ready) begin
                        sr  <= sr >> WORD_W;
                        idx <= idx + 10'd1;
                        if (idx == LAST_IDX) begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
`ifdef SK_STREAM_ZEROIZE_EN
                            sr        <= '0;
`endif
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
